// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: control decode, write-through register file, immediate
// generation, ID/EX boundary register, load-use stall detection and branch flush.
module id_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [31:0]        if_instr,
    input  logic [XLEN-1:0]    if_pc,
    input  logic               flush,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               hazard_stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_regwrite,
    output logic               ex_alusrc,
    output logic               ex_memwrite,
    output logic               ex_memread,
    output logic               ex_resultsrc,
    output logic               ex_branch,
    output logic [1:0]         ex_aluop,
    output logic               ex_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0]         opcode;
    logic [RADDR_W-1:0] rs1_idx;
    logic [RADDR_W-1:0] rs2_idx;
    logic [RADDR_W-1:0] rd_idx;
    logic [XLEN-1:0]    imm_i;
    logic [XLEN-1:0]    imm_s;
    logic [XLEN-1:0]    imm_b;
    logic               unused_instr;

    assign opcode  = if_instr[6:0];
    assign rs1_idx = if_instr[15 +: RADDR_W];
    assign rs2_idx = if_instr[20 +: RADDR_W];
    assign rd_idx  = if_instr[7 +: RADDR_W];
    assign imm_i   = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign imm_s   = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b   = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};
    assign unused_instr = ^if_instr;

    logic            dec_regwrite;
    logic            dec_alusrc;
    logic            dec_memwrite;
    logic            dec_memread;
    logic            dec_resultsrc;
    logic            dec_branch;
    logic [1:0]      dec_aluop;
    logic            dec_illegal;
    logic            use_rs1;
    logic            use_rs2;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        dec_regwrite  = 1'b0;
        dec_alusrc    = 1'b0;
        dec_memwrite  = 1'b0;
        dec_memread   = 1'b0;
        dec_resultsrc = 1'b0;
        dec_branch    = 1'b0;
        dec_aluop     = 2'b00;
        dec_illegal   = 1'b0;
        use_rs1       = 1'b0;
        use_rs2       = 1'b0;
        dec_imm       = '0;
        case (opcode)
            OP_R: begin
                dec_regwrite = 1'b1;
                dec_aluop    = 2'b10;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OP_IALU: begin
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
                dec_aluop    = 2'b10;
                use_rs1      = 1'b1;
                dec_imm      = imm_i;
            end
            OP_LOAD: begin
                dec_regwrite  = 1'b1;
                dec_alusrc    = 1'b1;
                dec_memread   = 1'b1;
                dec_resultsrc = 1'b1;
                use_rs1       = 1'b1;
                dec_imm       = imm_i;
            end
            OP_STORE: begin
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                dec_imm      = imm_s;
            end
            OP_BRANCH: begin
                dec_branch = 1'b1;
                dec_aluop  = 2'b01;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec_imm    = imm_b;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic [XLEN-1:0] regs [0:NREG-1];
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Write-through lets an instruction see a value being written back this same cycle.
    always_comb begin
        rs1_data = regs[rs1_idx];
        if (rs1_idx == '0)
            rs1_data = '0;
        else if (wb_we && wb_rd == rs1_idx)
            rs1_data = wb_data;
    end

    always_comb begin
        rs2_data = regs[rs2_idx];
        if (rs2_idx == '0)
            rs2_data = '0;
        else if (wb_we && wb_rd == rs2_idx)
            rs2_data = wb_data;
    end

    logic load_use;

    assign load_use = if_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                      ((use_rs1 && ex_rd == rs1_idx) || (use_rs2 && ex_rd == rs2_idx));
    assign hazard_stall = load_use && !flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_alusrc    <= 1'b0;
            ex_memwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_resultsrc <= 1'b0;
            ex_branch    <= 1'b0;
            ex_aluop     <= 2'b00;
            ex_illegal   <= 1'b0;
        end else begin
            ex_pc       <= if_pc;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_imm      <= dec_imm;
            ex_rs1      <= rs1_idx;
            ex_rs2      <= rs2_idx;
            // Bubbles carry no destination so forwarding and hazard logic ignore them.
            if (flush || hazard_stall || !if_valid) begin
                ex_valid     <= 1'b0;
                ex_rd        <= '0;
                ex_regwrite  <= 1'b0;
                ex_alusrc    <= 1'b0;
                ex_memwrite  <= 1'b0;
                ex_memread   <= 1'b0;
                ex_resultsrc <= 1'b0;
                ex_branch    <= 1'b0;
                ex_aluop     <= 2'b00;
                ex_illegal   <= 1'b0;
            end else begin
                ex_valid     <= 1'b1;
                ex_rd        <= rd_idx;
                ex_regwrite  <= dec_regwrite;
                ex_alusrc    <= dec_alusrc;
                ex_memwrite  <= dec_memwrite;
                ex_memread   <= dec_memread;
                ex_resultsrc <= dec_resultsrc;
                ex_branch    <= dec_branch;
                ex_aluop     <= dec_aluop;
                ex_illegal   <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a vector table for single-cycle decode plus
// hand sequences for reset, load-use stall, flush priority and reset during a stall.
module tb_id_stage_pipe;

    localparam int XLEN    = 32;
    localparam int NREG    = 32;
    localparam int RADDR_W = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               if_valid;
    logic [31:0]        if_instr;
    logic [XLEN-1:0]    if_pc;
    logic               flush;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               hazard_stall;
    logic               ex_valid;
    logic [XLEN-1:0]    ex_pc;
    logic [XLEN-1:0]    ex_rs1_data;
    logic [XLEN-1:0]    ex_rs2_data;
    logic [XLEN-1:0]    ex_imm;
    logic [RADDR_W-1:0] ex_rs1;
    logic [RADDR_W-1:0] ex_rs2;
    logic [RADDR_W-1:0] ex_rd;
    logic               ex_regwrite;
    logic               ex_alusrc;
    logic               ex_memwrite;
    logic               ex_memread;
    logic               ex_resultsrc;
    logic               ex_branch;
    logic [1:0]         ex_aluop;
    logic               ex_illegal;

    int checks   = 0;
    int failures = 0;

    id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc), .ex_memwrite(ex_memwrite),
        .ex_memread(ex_memread), .ex_resultsrc(ex_resultsrc), .ex_branch(ex_branch),
        .ex_aluop(ex_aluop), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid, flush, we;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        chk_data, chk_rd;
        logic        e_valid, e_regwrite, e_alusrc, e_memwrite, e_memread, e_resultsrc, e_branch;
        logic [1:0]  e_aluop;
        logic        e_illegal;
        logic [31:0] e_imm, e_rs1_data, e_rs2_data;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs [11];

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic valid, input logic fl, input logic we,
                                 input logic [4:0] wrd, input logic [31:0] wdata);
        if_instr = instr;
        if_pc    = pc;
        if_valid = valid;
        flush    = fl;
        wb_we    = we;
        wb_rd    = wrd;
        wb_data  = wdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".valid"}, 32'(ex_valid), 32'd0);
        checkOutput({tag, ".pc"}, ex_pc, 32'd0);
        checkOutput({tag, ".rs1_data"}, ex_rs1_data, 32'd0);
        checkOutput({tag, ".rs2_data"}, ex_rs2_data, 32'd0);
        checkOutput({tag, ".imm"}, ex_imm, 32'd0);
        checkOutput({tag, ".idx"}, 32'({ex_rs1, ex_rs2, ex_rd}), 32'd0);
        checkOutput({tag, ".ctrl"}, 32'({ex_regwrite, ex_alusrc, ex_memwrite, ex_memread,
                    ex_resultsrc, ex_branch, ex_aluop, ex_illegal}), 32'd0);
    endtask

    initial begin
        // Fields: instr, pc, valid, flush, we, wrd, wdata, chk_data, chk_rd,
        // valid, regwrite, alusrc, memwrite, memread, resultsrc, branch, aluop, illegal,
        // imm, rs1_data, rs2_data, rd
        vecs[0]  = '{32'h000281B3, 32'h100, 1, 0, 1, 5'd5, 32'hDEADBEEF, 1, 1,
                     1, 1, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd3};
        vecs[1]  = '{32'hFFC12083, 32'h104, 1, 0, 0, 5'd0, 32'h0, 1, 1,
                     1, 1, 1, 0, 1, 1, 0, 2'b00, 0, 32'hFFFFFFFC, 32'h1000, 32'h0, 5'd1};
        vecs[2]  = '{32'h00612A23, 32'h108, 1, 0, 0, 5'd0, 32'h0, 1, 1,
                     1, 0, 1, 1, 0, 0, 0, 2'b00, 0, 32'd20, 32'h1000, 32'h66, 5'd20};
        vecs[3]  = '{32'hFE208CE3, 32'h10C, 1, 0, 0, 5'd0, 32'h0, 1, 1,
                     1, 0, 0, 0, 0, 0, 1, 2'b01, 0, 32'hFFFFFFF8, 32'h0, 32'h1000, 5'd25};
        vecs[4]  = '{32'h0000007F, 32'h110, 1, 0, 0, 5'd0, 32'h0, 1, 1,
                     1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 32'h0, 32'h0, 32'h0, 5'd0};
        vecs[5]  = '{32'hFFF00413, 32'h114, 1, 0, 0, 5'd0, 32'h0, 1, 1,
                     1, 1, 1, 0, 0, 0, 0, 2'b10, 0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd8};
        vecs[6]  = '{32'h000004B3, 32'h118, 1, 0, 1, 5'd0, 32'h12345678, 1, 1,
                     1, 1, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 5'd9};
        vecs[7]  = '{32'h000004B3, 32'h11C, 1, 0, 0, 5'd0, 32'h0, 1, 1,
                     1, 1, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 5'd9};
        vecs[8]  = '{32'h000281B3, 32'h120, 0, 0, 0, 5'd0, 32'h0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0};
        vecs[9]  = '{32'h00138213, 32'h124, 1, 1, 0, 5'd0, 32'h0, 0, 1,
                     0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0};
        vecs[10] = '{32'h00138213, 32'h128, 1, 0, 1, 5'd7, 32'h100, 1, 1,
                     1, 1, 1, 0, 0, 0, 0, 2'b10, 0, 32'h1, 32'h100, 32'h0, 5'd4};

        // Reset with live traffic, including a writeback that must be ignored.
        rst = 1'b0;
        applyStimulus(32'h000281B3, 32'h40, 1, 0, 1, 5'd5, 32'hCAFEF00D);
        tick();
        tick();
        checkAllZero("reset");
        checkOutput("reset.stall", 32'(hazard_stall), 32'd0);
        rst = 1'b1;

        for (int i = 1; i < NREG; i++) begin
            applyStimulus({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'b0110011}, 32'h0, 1, 0, 0, 5'd0, 32'h0);
            tick();
            checkOutput($sformatf("reset_read.x%0d", i), ex_rs1_data | ex_rs2_data, 32'd0);
        end

        applyStimulus(32'h0, 32'h0, 0, 0, 1, 5'd2, 32'h1000); tick();
        applyStimulus(32'h0, 32'h0, 0, 0, 1, 5'd3, 32'h33);   tick();
        applyStimulus(32'h0, 32'h0, 0, 0, 1, 5'd6, 32'h66);   tick();
        applyStimulus(32'h0, 32'h0, 0, 0, 1, 5'd7, 32'h7);    tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].instr, vecs[i].pc, vecs[i].valid, vecs[i].flush,
                          vecs[i].we, vecs[i].wrd, vecs[i].wdata);
            #1;
            checkOutput($sformatf("vec%0d.stall", i), 32'(hazard_stall), 32'd0);
            tick();
            checkOutput($sformatf("vec%0d.valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
            checkOutput($sformatf("vec%0d.ctrl", i),
                        32'({ex_regwrite, ex_alusrc, ex_memwrite, ex_memread, ex_resultsrc, ex_branch}),
                        32'({vecs[i].e_regwrite, vecs[i].e_alusrc, vecs[i].e_memwrite,
                             vecs[i].e_memread, vecs[i].e_resultsrc, vecs[i].e_branch}));
            checkOutput($sformatf("vec%0d.aluop", i), 32'(ex_aluop), 32'(vecs[i].e_aluop));
            checkOutput($sformatf("vec%0d.illegal", i), 32'(ex_illegal), 32'(vecs[i].e_illegal));
            if (vecs[i].chk_data) begin
                checkOutput($sformatf("vec%0d.pc", i), ex_pc, vecs[i].pc);
                checkOutput($sformatf("vec%0d.imm", i), ex_imm, vecs[i].e_imm);
                checkOutput($sformatf("vec%0d.rs1_data", i), ex_rs1_data, vecs[i].e_rs1_data);
                checkOutput($sformatf("vec%0d.rs2_data", i), ex_rs2_data, vecs[i].e_rs2_data);
            end
            if (vecs[i].chk_rd)
                checkOutput($sformatf("vec%0d.rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
        end

        // Load-use: lw x1 then add x4,x1,x3 costs exactly one bubble.
        applyStimulus(32'h00012083, 32'h200, 1, 0, 0, 5'd0, 32'h0);
        #1 checkOutput("lu.lw_stall", 32'(hazard_stall), 32'd0);
        tick();
        checkOutput("lu.lw_memread", 32'(ex_memread), 32'd1);
        applyStimulus(32'h00308233, 32'h204, 1, 0, 0, 5'd0, 32'h0);
        #1 checkOutput("lu.stall_on", 32'(hazard_stall), 32'd1);
        tick();
        checkOutput("lu.bubble_valid", 32'(ex_valid), 32'd0);
        checkOutput("lu.bubble_regwrite", 32'(ex_regwrite), 32'd0);
        checkOutput("lu.stall_off", 32'(hazard_stall), 32'd0);
        tick();
        checkOutput("lu.add_valid", 32'(ex_valid), 32'd1);
        checkOutput("lu.add_regwrite", 32'(ex_regwrite), 32'd1);
        checkOutput("lu.add_rd", 32'(ex_rd), 32'd4);
        checkOutput("lu.add_rs1", 32'(ex_rs1), 32'd1);
        checkOutput("lu.add_rs2_data", ex_rs2_data, 32'h33);
        applyStimulus(32'h00138213, 32'h208, 1, 0, 0, 5'd0, 32'h0);
        #1 checkOutput("lu.addi_stall", 32'(hazard_stall), 32'd0);
        tick();
        checkOutput("lu.addi_valid", 32'(ex_valid), 32'd1);
        checkOutput("lu.addi_rs1_data", ex_rs1_data, 32'h100);

        // A load into x0 never stalls its consumer.
        applyStimulus(32'h00012003, 32'h20C, 1, 0, 0, 5'd0, 32'h0);
        tick();
        checkOutput("x0.lw_memread", 32'(ex_memread), 32'd1);
        applyStimulus(32'h000002B3, 32'h210, 1, 0, 0, 5'd0, 32'h0);
        #1 checkOutput("x0.stall", 32'(hazard_stall), 32'd0);
        tick();
        checkOutput("x0.valid", 32'(ex_valid), 32'd1);

        // Flush wins over a live load-use condition.
        applyStimulus(32'h00012083, 32'h214, 1, 0, 0, 5'd0, 32'h0);
        tick();
        applyStimulus(32'h00308233, 32'h218, 1, 1, 0, 5'd0, 32'h0);
        #1 checkOutput("fl.stall", 32'(hazard_stall), 32'd0);
        tick();
        checkOutput("fl.valid", 32'(ex_valid), 32'd0);
        checkOutput("fl.regwrite", 32'(ex_regwrite), 32'd0);
        checkOutput("fl.rd", 32'(ex_rd), 32'd0);

        // Reset asserted while stalled.
        applyStimulus(32'h00012083, 32'h21C, 1, 0, 0, 5'd0, 32'h0);
        tick();
        applyStimulus(32'h00308233, 32'h220, 1, 0, 0, 5'd0, 32'h0);
        #1 checkOutput("rs.stall_on", 32'(hazard_stall), 32'd1);
        rst = 1'b0;
        tick();
        checkAllZero("rs");
        checkOutput("rs.stall_off", 32'(hazard_stall), 32'd0);
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
